// File: rtl/irq_ctrl_n.sv
// N-channel interrupt controller: per-channel edge/level pending latches, arbitration, mcause, per-channel ack.
// Define IRQ_CTRL_RR_EN for round-robin arbitration; the default is fixed priority with the lowest index winning.
module irq_ctrl_n #(
  parameter int          N_IRQ       = 16,
  parameter logic [31:0] TRIG_EDGE   = 32'h0000_0000,
  parameter int          MCAUSE_BASE = 16
) (
  input  logic             clk_i,
  input  logic             rstn,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic [31:0]      mie_i,
  input  logic             int_rst_i,
  output logic             int_o,
  output logic [31:0]      mcause_o,
  output logic [N_IRQ-1:0] irq_ret_o
);
  localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
  localparam logic [N_IRQ-1:0] EDGE_MASK = TRIG_EDGE[N_IRQ-1:0];

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state;
  logic [N_IRQ-1:0] pend, irq_q, edge_det, eligible, pend_nxt;
  logic [IW-1:0]    cur_idx, win_idx;
  logic             done;
  logic             unused_mie;

  assign edge_det   = irq_i & ~irq_q;
  assign eligible   = pend & mie_i[N_IRQ-1:0];
  assign done       = (state == BUSY) && int_rst_i;
  assign unused_mie = &{1'b0, mie_i};

  // Completion clears an edge latch, but a coincident new edge re-sets it.
  always_comb begin
    pend_nxt = pend;
    if (done) pend_nxt[cur_idx] = 1'b0;
    pend_nxt = ((pend_nxt | edge_det) & EDGE_MASK) | (irq_i & ~EDGE_MASK);
  end

`ifdef IRQ_CTRL_RR_EN
  logic [IW-1:0] last_served;
  logic          found;

  always_comb begin
    win_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < N_IRQ; k++) begin
      int j;
      j = (int'(last_served) + 1 + k) % N_IRQ;
      if (!found && eligible[j]) begin
        win_idx = IW'(j);
        found   = 1'b1;
      end
    end
  end
`else
  always_comb begin
    win_idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--)
      if (eligible[i]) win_idx = IW'(i);
  end
`endif

  always_ff @(posedge clk_i) begin
    if (!rstn) begin
      state     <= IDLE;
      pend      <= '0;
      irq_q     <= '0;
      cur_idx   <= '0;
      int_o     <= 1'b0;
      mcause_o  <= '0;
      irq_ret_o <= '0;
`ifdef IRQ_CTRL_RR_EN
      last_served <= IW'(N_IRQ - 1);
`endif
    end else begin
      irq_q     <= irq_i;
      pend      <= pend_nxt;
      irq_ret_o <= '0;
      case (state)
        IDLE: begin
          if (|eligible) begin
            cur_idx  <= win_idx;
            mcause_o <= 32'h8000_0000 | (32'(MCAUSE_BASE) + 32'(win_idx));
            int_o    <= 1'b1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          // Request is held regardless of irq_i/mie_i until the core acknowledges.
          if (int_rst_i) begin
            irq_ret_o[cur_idx] <= 1'b1;
            int_o              <= 1'b0;
            state              <= IDLE;
`ifdef IRQ_CTRL_RR_EN
            last_served <= cur_idx;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_irq_ctrl_n.sv
// Directed bench for irq_ctrl_n: channel 0 edge-triggered, all others level-triggered.
module tb_irq_ctrl_n;
  logic        clk_i = 1'b0;
  logic        rstn;
  logic [15:0] irq_i;
  logic [31:0] mie_i;
  logic        int_rst_i;
  logic        int_o;
  logic [31:0] mcause_o;
  logic [15:0] irq_ret_o;

  int n_chk  = 0;
  int n_pass = 0;

  irq_ctrl_n #(.N_IRQ(16), .TRIG_EDGE(32'h1), .MCAUSE_BASE(16)) dut (
    .clk_i(clk_i), .rstn(rstn), .irq_i(irq_i), .mie_i(mie_i), .int_rst_i(int_rst_i),
    .int_o(int_o), .mcause_o(mcause_o), .irq_ret_o(irq_ret_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk3(input string tag, input logic io, input logic [31:0] mc, input logic [15:0] ret);
    chk({tag, ".int"}, {31'b0, int_o}, {31'b0, io});
    chk({tag, ".mcause"}, mcause_o, mc);
    chk({tag, ".ret"}, {16'b0, irq_ret_o}, {16'b0, ret});
  endtask

  initial begin
    logic [31:0] rr_exp [3];
`ifdef IRQ_CTRL_RR_EN
    rr_exp = '{32'h8000_0011, 32'h8000_0012, 32'h8000_0011};
`else
    rr_exp = '{32'h8000_0011, 32'h8000_0011, 32'h8000_0011};
`endif
    // Reset with every request line high
    rstn = 1'b0; irq_i = 16'hFFFF; mie_i = 32'hFFFF_FFFF; int_rst_i = 1'b0;
    tick(); tick();
    chk3("reset", 1'b0, 32'h0, 16'h0);
    irq_i = 16'h0; mie_i = 32'h0; rstn = 1'b1;
    tick();
    chk3("post_reset", 1'b0, 32'h0, 16'h0);

    // Single level IRQ on channel 2: two-cycle latency
    mie_i = 32'h4; irq_i = 16'h0004;
    tick();
    chk("lvl2.lat1", {31'b0, int_o}, 32'h0);
    tick();
    chk3("lvl2.busy", 1'b1, 32'h8000_0012, 16'h0);
    int_rst_i = 1'b1; irq_i = 16'h0;
    tick();
    chk3("lvl2.ack", 1'b0, 32'h8000_0012, 16'h0004);
    int_rst_i = 1'b0;
    tick();
    chk3("lvl2.idle", 1'b0, 32'h8000_0012, 16'h0);

    // Masked channel 5 held for 10 cycles, then enabled
    mie_i = 32'h0; irq_i = 16'h0020;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("masked5", {31'b0, int_o}, 32'h0);
    end
    mie_i = 32'h20;
    tick();
    chk3("unmask5", 1'b1, 32'h8000_0015, 16'h0);
    int_rst_i = 1'b1; irq_i = 16'h0;
    tick();
    chk3("unmask5.ack", 1'b0, 32'h8000_0015, 16'h0020);
    int_rst_i = 1'b0;
    tick();

    // Fixed priority 3 before 7; clearing mie mid-service must not withdraw
    mie_i = 32'hFFFF_FFFF; irq_i = 16'h0088;
    tick(); tick();
    chk3("prio.3", 1'b1, 32'h8000_0013, 16'h0);
    mie_i = 32'h0;
    tick();
    chk3("prio.3.mie_off", 1'b1, 32'h8000_0013, 16'h0);
    mie_i = 32'hFFFF_FFFF; int_rst_i = 1'b1; irq_i = 16'h0080;
    tick();
    chk3("prio.3.ack", 1'b0, 32'h8000_0013, 16'h0008);
    int_rst_i = 1'b0;
    tick();
    chk3("prio.7", 1'b1, 32'h8000_0017, 16'h0);
    int_rst_i = 1'b1; irq_i = 16'h0;
    tick();
    chk3("prio.7.ack", 1'b0, 32'h8000_0017, 16'h0080);
    int_rst_i = 1'b0;
    tick();
    chk("prio.idle", {31'b0, int_o}, 32'h0);

    // Edge channel 0: new pulse coincident with ack is not lost
    mie_i = 32'h1; irq_i = 16'h0001;
    tick();
    irq_i = 16'h0;
    tick();
    chk3("edge0.busy", 1'b1, 32'h8000_0010, 16'h0);
    irq_i = 16'h0001; int_rst_i = 1'b1;
    tick();
    chk3("edge0.ack", 1'b0, 32'h8000_0010, 16'h0001);
    irq_i = 16'h0; int_rst_i = 1'b0;
    tick();
    chk3("edge0.rearm", 1'b1, 32'h8000_0010, 16'h0);
    int_rst_i = 1'b1;
    tick();
    chk("edge0.ack2", {16'b0, irq_ret_o}, 32'h1);
    int_rst_i = 1'b0;
    tick();
    chk("edge0.idle", {31'b0, int_o}, 32'h0);
    tick();
    chk("edge0.no_retrig", {31'b0, int_o}, 32'h0);

    // Reset in BUSY aborts without an acknowledge pulse
    mie_i = 32'hFFFF_FFFF; irq_i = 16'h0002;
    tick(); tick();
    chk("abort.busy", {31'b0, int_o}, 32'h1);
    rstn = 1'b0; int_rst_i = 1'b1; irq_i = 16'h0;
    tick();
    chk3("abort.reset", 1'b0, 32'h0, 16'h0);
    rstn = 1'b1; int_rst_i = 1'b0;
    tick();
    chk("abort.after", {16'b0, irq_ret_o}, 32'h0);

    // Channels 1 and 2 permanently high: three service rounds
    irq_i = 16'h0006;
    tick(); tick();
    for (int r = 0; r < 3; r++) begin
      chk($sformatf("rr.sel%0d", r), mcause_o, rr_exp[r]);
      chk($sformatf("rr.int%0d", r), {31'b0, int_o}, 32'h1);
      int_rst_i = 1'b1;
      tick();
      chk($sformatf("rr.ret%0d", r), {16'b0, irq_ret_o}, 32'h1 << (rr_exp[r][3:0]));
      chk($sformatf("rr.gap%0d", r), {31'b0, int_o}, 32'h0);
      int_rst_i = 1'b0;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
